aes_key_schedule: RTL and testbench

//  Sequential AES-128 key expansion (FIPS-197 5.2), one round key per accepted handshake.

---
 rtl/aes_key_schedule.sv | 93 +++++++++
 tb/tb_aes_key_schedule.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion, one round key per valid/ready handshake
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         round_key_valid,
  input  logic         round_key_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [127:0] key, key_nx;
  logic [3:0] idx, idx_nx;
  logic [7:0] rcon, rcon_nx;
  logic done_q, done_nx;
  logic [31:0] w3, t, n0, n1, n2, n3;
  logic hs;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254 by repeated squaring) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  assign w3 = key[31:0];
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
  assign n0 = key[127:96] ^ t;
  assign n1 = key[95:64] ^ n0;
  assign n2 = key[63:32] ^ n1;
  assign n3 = w3 ^ n2;
  assign hs = state == RUN && round_key_ready;
  // start is blocked on the done cycle so a new run begins only once the previous one has fully retired
  always_comb begin
    state_nx = state;
    key_nx = key;
    idx_nx = idx;
    rcon_nx = rcon;
    done_nx = 1'b0;
    if (state == IDLE && start && !done_q) begin
      state_nx = RUN;
      key_nx = cipher_key;
      idx_nx = 4'd0;
      rcon_nx = 8'h01;
    end else if (hs && idx == 4'(NR)) begin
      state_nx = IDLE;
      done_nx = 1'b1;
    end else if (hs) begin
      key_nx = {n0, n1, n2, n3};
      idx_nx = idx + 4'd1;
      rcon_nx = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      key <= '0;
      idx <= '0;
      rcon <= 8'h01;
      done_q <= 1'b0;
    end else begin
      state <= state_nx;
      key <= key_nx;
      idx <= idx_nx;
      rcon <= rcon_nx;
      done_q <= done_nx;
    end
  end
  assign round_key = key;
  assign round_idx = idx;
  assign round_key_valid = state == RUN;
  assign busy = state == RUN;
  assign done = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: table-driven FIPS vectors plus a scoreboard fed by a table-based key-expansion model
module tb_aes_key_schedule;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [127:0] cipher_key = '0, round_key;
  logic [3:0] round_idx;
  logic round_key_valid, busy, done;
  aes_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cipher_key(cipher_key),
    .round_key(round_key), .round_idx(round_idx), .round_key_valid(round_key_valid),
    .round_key_ready(ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] idx; logic [127:0] key;} sb_t;
  typedef struct {logic [127:0] key; int idx; logic [127:0] exp;} vec_t;
  sb_t sb[$];
  logic [127:0] got [0:15];
  int nvec = 0, nerr = 0, ndone = 0, nvalid = 0, rmode = 0, stall = 0;
  logic exp_busy = 1'b0, pend_done = 1'b0;
  localparam logic [127:0] A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [7:0] rcon [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  function automatic logic [127:0] model(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    for (int i = 1; i <= r; i++) begin
      t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon[i-1], 24'h0};
      w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    end
    return {w0, w1, w2, w3};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // one clock: check what the last edge produced, then drive and predict the next edge
  task automatic cycle(input logic st, input logic [127:0] k);
    logic rdy, hs, fin, acc;
    @(negedge clk);
    chk("done", 128'(done), 128'(pend_done));
    chk("busy", 128'(busy), 128'(exp_busy));
    chk("valid", 128'(round_key_valid), 128'(exp_busy));
    if (done) ndone++;
    if (round_key_valid) nvalid++;
    rdy = rmode == 2 ? 1'($urandom_range(0, 1)) :
          (rmode == 1 && round_key_valid && round_idx == 4'd4 && stall < 3) ? 1'b0 : 1'b1;
    if (!rdy && rmode == 1) stall++;
    if (rmode == 3 && round_key_valid && round_idx == 4'd5) begin st = 1'b1; k = '0; end
    fin = 1'b0;
    if (round_key_valid && sb.size() > 0) begin
      chk("idx", 128'(round_idx), 128'(sb[0].idx));
      chk("key", round_key, sb[0].key);
      hs = rdy;
      fin = hs && sb[0].idx == 4'd10;
      if (hs) begin got[round_idx] = round_key; void'(sb.pop_front()); end
    end
    acc = st && !exp_busy && !pend_done;
    if (acc) for (int r = 0; r <= 10; r++) sb.push_back('{4'(r), model(k, r)});
    ready = rdy; start = st; cipher_key = k;
    pend_done = fin;
    exp_busy = acc ? 1'b1 : fin ? 1'b0 : exp_busy;
  endtask
  task automatic drain();
    int g = 0;
    while ((exp_busy || pend_done) && g < 300) begin cycle(1'b0, '0); g++; end
    if (g >= 300) chk("drain_timeout", 128'(g), 128'(0));
  endtask
  task automatic run(input logic [127:0] k, input int mode);
    int d0 = ndone, v0 = nvalid;
    rmode = mode; stall = 0;
    cycle(1'b1, k);
    drain();
    chk("one_done", 128'(ndone - d0), 128'(1));
    if (mode == 0) chk("valid_cycles", 128'(nvalid - v0), 128'(11));
    if (mode == 1) chk("stall_cycles", 128'(stall), 128'(3));
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_key"}, round_key, '0);
    chk({nm, "_idx"}, 128'(round_idx), '0);
    chk({nm, "_flags"}, 128'({round_key_valid, busy, done}), '0);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("areset");
    sb.delete(); exp_busy = 1'b0; pend_done = 1'b0;
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    vec_t vt [6];
    int g;
    vt[0] = '{A1, 0, A1};
    vt[1] = '{A1, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{A1, 2, 128'hf2c295f27a96b9435935807a7359f67f};
    vt[3] = '{A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[4] = '{128'h0, 1, 128'h62636363626363636263636362636363};
    vt[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    #12 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) cycle(1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      run(vt[i].key, i % 3);
      chk($sformatf("vec%0d_idx%0d", i, vt[i].idx), got[vt[i].idx], vt[i].exp);
    end
    run(A1, 3);
    chk("start_in_run_idx10", got[10], vt[3].exp);
    rmode = 0;
    cycle(1'b1, A1);
    g = 0;
    while (!(round_key_valid && round_idx == 4'd5) && g < 50) begin cycle(1'b0, '0); g++; end
    do_reset();
    repeat (2) cycle(1'b0, '0);
    run(128'h0, 0);
    chk("after_reset_idx1", got[1], vt[4].exp);
    chk("after_reset_idx10", got[10], vt[5].exp);
    cycle(1'b1, A1);
    g = 0;
    while (!pend_done && g < 50) begin cycle(1'b0, '0); g++; end
    cycle(1'b1, 128'h0);
    cycle(1'b1, 128'h00112233445566778899aabbccddeeff);
    cycle(1'b0, '0);
    drain();
    for (int i = 0; i < 100; i++) run({$urandom, $urandom, $urandom, $urandom}, 2);
    repeat (2) cycle(1'b0, '0);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
